// File: rtl/led_pattern_gen.sv
// LED pattern generator (binary up/down, Gray, bounce) advanced by a prescaler or manual step.
// Latency: leds/tick register one cycle after the advance cycle; no backpressure, advances are never stalled.
module led_pattern_gen #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] leds,
    output logic             tick
);

    localparam int DIV  = CLK_FREQ / TICK_HZ;
    localparam int PW   = $clog2(DIV);
    localparam int POSW = $clog2(WIDTH);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [POSW-1:0] POS_TOP    = POSW'(WIDTH - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [POSW-1:0]  pos_q, pos_d;
    dir_t             dir_q, dir_d;
    logic [1:0]       mode_q;
    logic             mode_chg;
    logic             advance;
    logic [WIDTH-1:0] leds_d;

    always_comb begin
        mode_chg = (mode != mode_q);
        advance  = 1'b0;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        dir_d    = dir_q;

        if (mode_chg) begin
            // A mode switch restarts the new pattern and swallows any advance this cycle.
            presc_d = '0;
            cnt_d   = '0;
            pos_d   = '0;
            dir_d   = DIR_UP;
        end else begin
            if (run) begin
                advance = (presc_q == PRESC_LAST);
                presc_d = advance ? '0 : presc_q + PW'(1);
            end else begin
                advance = step;
            end

            if (advance) begin
                case (mode_q)
                    2'd1: cnt_d = cnt_q - WIDTH'(1);
                    2'd3: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_TOP) begin
                                dir_d = DIR_DOWN;
                                pos_d = POS_TOP - POSW'(1);
                            end else begin
                                pos_d = pos_q + POSW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = POSW'(1);
                            end else begin
                                pos_d = pos_q - POSW'(1);
                            end
                        end
                    end
                    default: cnt_d = cnt_q + WIDTH'(1);
                endcase
            end
        end

        // Outside a mode change mode equals mode_q, so mode selects the next pattern either way.
        case (mode)
            2'd2:    leds_d = cnt_d ^ (cnt_d >> 1);
            2'd3:    leds_d = WIDTH'(1) << pos_d;
            default: leds_d = cnt_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            mode_q  <= 2'd0;
            leds    <= '0;
            tick    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            mode_q  <= mode;
            leds    <= leds_d;
            tick    <= advance;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (DIV=4, WIDTH=4): closed-form pattern model checked every cycle,
// directed scenarios pinned with literal values, then randomized run/step/mode/reset traffic.
module tb_led_pattern_gen;

    localparam int W   = 4;
    localparam int DIV = 4;
    localparam int P   = 2 * W - 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] leds;
    logic         tick;

    led_pattern_gen #(.CLK_FREQ(4), .TICK_HZ(1), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .step  (step),
        .mode  (mode),
        .leds  (leds),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           chk_en = 1'b0;
    int           m_phase = 0;
    int           m_k = 0;
    logic [1:0]   m_mode = 2'd0;
    logic [W-1:0] m_leds = '0;
    logic         m_tick = 1'b0;
    logic [W-1:0] seen[$];

    localparam logic [3:0] GRAY_SEQ [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    localparam logic [3:0] BOUNCE_SEQ [12] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1,
                                               4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};

    // Pattern value after k advances since the mode was (re)loaded.
    function automatic logic [W-1:0] pat(input logic [1:0] md, input int k);
        int v, r, p;
        v = k % (1 << W);
        case (md)
            2'd0:    return W'(v);
            2'd1:    return W'(((1 << W) - v) % (1 << W));
            2'd2:    return W'(v ^ (v >> 1));
            default: begin
                r = k % P;
                p = (r < W) ? r : P - r;
                return W'(1 << p);
            end
        endcase
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_update();
        bit adv;
        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_mode = 2'd0; m_leds = '0; m_tick = 1'b0;
        end else if (mode != m_mode) begin
            m_mode = mode; m_phase = 0; m_k = 0; m_tick = 1'b0;
            m_leds = pat(mode, 0);
        end else begin
            adv = run ? (m_phase == DIV - 1) : step;
            if (run) m_phase = (m_phase + 1) % DIV;
            if (adv) m_k++;
            m_tick = adv;
            m_leds = pat(m_mode, m_k);
        end
    endtask

    task automatic cyc(input logic rn, input logic r, input logic st, input logic [1:0] md);
        rst_n = rn; run = r; step = st; mode = md;
        @(posedge clk);
        model_update();
        chk_en = 1'b1;
        @(negedge clk);
        if (tick === 1'b1) seen.push_back(leds);
    endtask

    task automatic run_n(input int n, input logic r, input logic st, input logic [1:0] md);
        for (int i = 0; i < n; i++) cyc(1'b1, r, st, md);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("leds_model", leds, m_leds);
            check("tick_model", tick, m_tick);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 2'd0);
        check("reset_leds", leds, 0);
        check("reset_tick", tick, 0);

        // Mode 0: 16 advances wrap F -> 0.
        seen.delete();
        run_n(64, 1'b1, 1'b0, 2'd0);
        check("m0_tick_count", seen.size(), 16);
        if (seen.size() == 16) begin
            check("m0_first", seen[0], 4'h1);
            check("m0_last_before_wrap", seen[14], 4'hF);
            check("m0_wrap", seen[15], 4'h0);
        end

        // Mode 1: down counter wraps 0 -> F.
        run_n(1, 1'b1, 1'b0, 2'd1);
        check("m1_load_leds", leds, 0);
        check("m1_load_tick", tick, 0);
        seen.delete();
        run_n(16, 1'b1, 1'b0, 2'd1);
        check("m1_tick_count", seen.size(), 4);
        if (seen.size() == 4) check("m1_first", seen[0], 4'hF);
        check("m1_leds", leds, 4'hC);

        // Mode 2: Gray sequence.
        run_n(1, 1'b1, 1'b0, 2'd2);
        seen.delete();
        run_n(64, 1'b1, 1'b0, 2'd2);
        check("m2_tick_count", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++) check("m2_gray", seen[i], GRAY_SEQ[i]);

        // Mode 3: bounce, no repeated end positions.
        run_n(1, 1'b1, 1'b0, 2'd3);
        check("m3_load", leds, 4'h1);
        seen.delete();
        run_n(48, 1'b1, 1'b0, 2'd3);
        check("m3_tick_count", seen.size(), 12);
        for (int i = 0; i < 12 && i < seen.size(); i++) check("m3_bounce", seen[i], BOUNCE_SEQ[i]);

        // Pause, manual step, step ignored while running.
        seen.delete();
        run_n(20, 1'b0, 1'b0, 2'd3);
        check("pause_frozen", leds, 4'h1);
        check("pause_no_tick", seen.size(), 0);
        cyc(1'b1, 1'b0, 1'b1, 2'd3);
        check("step_leds", leds, 4'h2);
        check("step_tick", tick, 1);
        cyc(1'b1, 1'b0, 1'b0, 2'd3);
        check("step_once", tick, 0);
        seen.delete();
        run_n(4, 1'b1, 1'b1, 2'd3);
        check("step_while_run", seen.size(), 1);
        check("step_while_run_leds", leds, 4'h4);

        // Mode change mid-count: 0 -> 3 at leds=5.
        run_n(1, 1'b1, 1'b0, 2'd0);
        run_n(20, 1'b1, 1'b0, 2'd0);
        check("chg_pre", leds, 4'h5);
        run_n(1, 1'b1, 1'b0, 2'd3);
        check("chg_leds", leds, 4'h1);
        check("chg_tick", tick, 0);
        run_n(3, 1'b1, 1'b0, 2'd3);
        check("chg_hold", leds, 4'h1);
        run_n(1, 1'b1, 1'b0, 2'd3);
        check("chg_first_adv", leds, 4'h2);

        // Reset mid-sweep while heading down.
        run_n(12, 1'b1, 1'b0, 2'd3);
        check("sweep_down", leds, 4'h4);
        run_n(2, 1'b1, 1'b0, 2'd3);
        cyc(1'b0, 1'b1, 1'b1, 2'd3);
        check("midreset_leds", leds, 0);
        check("midreset_tick", tick, 0);
        cyc(1'b1, 1'b1, 1'b0, 2'd3);
        check("post_reset_load", leds, 4'h1);
        run_n(4, 1'b1, 1'b0, 2'd3);
        check("post_reset_adv1", leds, 4'h2);
        run_n(4, 1'b1, 1'b0, 2'd3);
        check("post_reset_dir_up", leds, 4'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] md;
            md = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(0, 3)) : mode;
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), md);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, clk frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, pattern advance rate in Hz; DIV = CLK_FREQ/TICK_HZ, legal only for DIV >= 2.
REQ-003 Parameter WIDTH, default 8, LED count, legal range 2..32.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 run  input  1  1 = free-running advance, 0 = paused.
REQ-007 step  input  1  single-cycle pulse that requests one manual advance while paused.
REQ-008 mode  input  2  pattern select: 0 binary up, 1 binary down, 2 Gray up, 3 bounce.
REQ-009 leds  output  WIDTH  registered pattern output.
REQ-010 tick  output  1  registered, high for exactly one cycle, coincident with each new leds value produced by an advance.

Function
REQ-011 The block SHALL contain a prescaler counting 0..DIV-1; when run=1 it increments each cycle and wraps DIV-1 -> 0, and the wrap cycle SHALL produce one advance.
REQ-012 When run=0, the prescaler SHALL hold its value, so free-running resumes with no phase loss.
REQ-013 When run=0 and step=1, the block SHALL perform exactly one advance per step-high cycle, and the prescaler SHALL remain unchanged.
REQ-014 When run=1, step SHALL be ignored.
REQ-015 Advance latency: leds and tick SHALL update on the clock edge that ends the advance cycle (one-cycle latency); tick SHALL be 0 in all other cycles.
REQ-016 The registered mode_q SHALL track mode; a cycle with mode != mode_q SHALL:
- load mode_q <= mode;
- clear the prescaler;
- load the new mode's initial state;
- suppress any advance in that cycle (mode change wins over advance and step);
- leave tick 0.
REQ-017 Mode 0: WIDTH-bit counter cnt; advance cnt <= cnt+1, wrapping all-ones -> 0; leds = cnt; initial cnt = 0.
REQ-018 Mode 1: advance cnt <= cnt-1, wrapping 0 -> all-ones; leds = cnt; initial cnt = 0.
REQ-019 Mode 2: cnt increments as in mode 0; leds = cnt ^ (cnt >> 1); initial cnt = 0, so leds = 0.
REQ-020 Mode 3: position pos (0..WIDTH-1) and direction dir (up/down); leds = one-hot 1<<pos; initial pos = 0, dir = up.
REQ-021 Mode 3 advance rules:
- up and pos<WIDTH-1: pos+1;
- up and pos=WIDTH-1: dir <= down, pos <= WIDTH-2;
- down and pos>0: pos-1;
- down and pos=0: dir <= up, pos <= 1.
- The period is 2*WIDTH-2 advances, and no end position repeats.
REQ-022 All arithmetic SHALL be modulo 2^WIDTH; the prescaler SHALL be at least clog2(DIV) bits and SHALL never exceed DIV-1.
REQ-023 leds SHALL be glitch-free register outputs; no combinational path from inputs to leds or tick.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL load prescaler=0, cnt=0, pos=0, dir=up, mode_q=0, leds=0, and tick=0.
REQ-025 Reset SHALL override run, step, and mode changes, including in the middle of a prescaler period or a bounce sweep.
REQ-026 If mode != 0 at reset release, the first post-reset cycle SHALL perform the mode change of REQ-016.

Verification (CLK_FREQ=4, TICK_HZ=1, i.e. DIV=4, WIDTH=4 unless stated)
REQ-027 Mode 0, run=1 -> leds 0,1,2,... changing every 4 cycles, one-cycle tick with each change, and F -> 0 wrap after 16 advances.
REQ-028 Mode 1, run=1 -> leds 0,F,E,D,... every 4 cycles; Mode 2 -> leds 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
REQ-029 Mode 3, run=1 -> leds 1,2,4,8,4,2,1,2,... with no repeated 8 or 1 at the ends.
REQ-030 run=0 for 20 cycles -> leds and prescaler frozen, tick 0; step pulse -> leds advances once next cycle with tick=1; step while run=1 -> no extra advance.
REQ-031 Mode 0 at leds=5, mode set to 3 -> next edge leds=1 with prescaler=0 and tick=0, then the first advance 4 cycles later gives leds=2.
REQ-032 rst_n=0 for one cycle mid-sweep (mode 3, leds=4, dir down) -> leds=0 and tick=0; with mode still 3 the next cycle gives leds=1 and dir=up.
